// File: rtl/clkdiv_cfg_ctrl.sv
// clkdiv_cfg_ctrl: configuration sequencer for the RX clock divider.
// A new prescale is decoded into a divide ratio. The divider is stopped only
// while the receiver is idle. The ratio is swapped after a settle period, and
// the divider is then re-enabled, so the divided clock never glitches mid-frame.
module clkdiv_cfg_ctrl #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cfg_valid_i,
    input  logic [5:0] cfg_prescale_i,
    output logic       cfg_ready_o,
    output logic       cfg_done_o,
    output logic       cfg_err_o,
    input  logic       rx_busy_i,
    output logic       div_en_o,
    output logic [3:0] div_ratio_o,
    output logic [5:0] cur_prescale_o
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_IDLE = 2'd1,
        S_GATE      = 2'd2,
        S_LOAD      = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    // Prescale to divide ratio; zero marks an illegal prescale (no fallback).
    function automatic logic [3:0] decode_ratio(input logic [5:0] prescale);
        logic [3:0] ratio;
        case (prescale)
            6'd32:   ratio = 4'd1;
            6'd16:   ratio = 4'd2;
            6'd8:    ratio = 4'd4;
            6'd4:    ratio = 4'd8;
            default: ratio = 4'd0;
        endcase
        return ratio;
    endfunction

    state_t                 state_q;
    logic                   ready_q;
    logic                   done_q;
    logic                   err_q;
    logic                   en_q;
    logic [3:0]             ratio_q;
    logic [5:0]             cur_prescale_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [3:0]             pend_ratio_q;
    logic [5:0]             pend_prescale_q;
    logic [3:0]             req_ratio_d;

    // Decode the incoming request combinationally, ahead of the accept edge.
    always_comb begin
        req_ratio_d = decode_ratio(cfg_prescale_i);
    end

    // Sequencer FSM; every output is a register written here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= S_IDLE;
            ready_q         <= 1'b1;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            en_q            <= 1'b1;
            ratio_q         <= 4'd1;
            cur_prescale_q  <= 6'd32;
            cnt_q           <= '0;
            pend_ratio_q    <= 4'd0;
            pend_prescale_q <= 6'd0;
        end else begin
            // Completion and error flags are single-cycle pulses.
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cfg_valid_i) begin
                        if (req_ratio_d == 4'd0) begin
                            err_q <= 1'b1;
                        end else if (req_ratio_d == ratio_q) begin
                            // Nothing to change: acknowledge without gating.
                            done_q <= 1'b1;
                        end else begin
                            pend_ratio_q    <= req_ratio_d;
                            pend_prescale_q <= cfg_prescale_i;
                            ready_q         <= 1'b0;
                            state_q         <= S_WAIT_IDLE;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    // Never stop the divider while a frame is being received.
                    if (!rx_busy_i) begin
                        en_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_GATE;
                    end
                end
                S_GATE: begin
                    if (cnt_q == CNT_LAST) begin
                        ratio_q        <= pend_ratio_q;
                        cur_prescale_q <= pend_prescale_q;
                        state_q        <= S_LOAD;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_LOAD: begin
                    // New ratio has been stable for a cycle; restart the divider.
                    en_q    <= 1'b1;
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready_o    = ready_q;
    assign cfg_done_o     = done_q;
    assign cfg_err_o      = err_q;
    assign div_en_o       = en_q;
    assign div_ratio_o    = ratio_q;
    assign cur_prescale_o = cur_prescale_q;

endmodule

// File: tb/tb_clkdiv_cfg_ctrl.sv
// Testbench for clkdiv_cfg_ctrl: directed requests against a timestamp-based
// behavioural model, with literal expectations for latency and ratio values.
module tb_clkdiv_cfg_ctrl;

    localparam int S     = 4;
    localparam int LIMIT = 60;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cfg_valid = 1'b0;
    logic [5:0] cfg_prescale = 6'd0;
    logic       rx_busy = 1'b0;
    logic       cfg_ready;
    logic       cfg_done;
    logic       cfg_err;
    logic       div_en;
    logic [3:0] div_ratio;
    logic [5:0] cur_prescale;

    int total = 0;
    int bad   = 0;

    clkdiv_cfg_ctrl #(.SETTLE_CYCLES(S), .CNT_WIDTH(3)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .cfg_valid_i    (cfg_valid),
        .cfg_prescale_i (cfg_prescale),
        .cfg_ready_o    (cfg_ready),
        .cfg_done_o     (cfg_done),
        .cfg_err_o      (cfg_err),
        .rx_busy_i      (rx_busy),
        .div_en_o       (div_en),
        .div_ratio_o    (div_ratio),
        .cur_prescale_o (cur_prescale)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int ref_ratio(input int p);
        case (p)
            32: return 1;
            16: return 2;
            8:  return 4;
            4:  return 8;
            default: return 0;
        endcase
    endfunction

    // Behavioural model: events of a change are placed on a timeline relative
    // to the edge where the receiver was first seen idle.
    int m_ready = 1, m_done = 0, m_err = 0, m_en = 1, m_ratio = 1, m_pre = 32;
    int cyc = 0, gate_e = 0, p_ratio = 0, p_pre = 0;
    bit active = 1'b0, waiting = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready = 1; m_done = 0; m_err = 0; m_en = 1; m_ratio = 1; m_pre = 32;
            active = 1'b0; waiting = 1'b0;
        end else begin
            int r;
            cyc++;
            m_done = 0;
            m_err  = 0;
            if (active) begin
                if (waiting) begin
                    if (!rx_busy) begin
                        waiting = 1'b0;
                        gate_e  = cyc;
                        m_en    = 0;
                    end
                end else begin
                    if (cyc == gate_e + S) begin
                        m_ratio = p_ratio;
                        m_pre   = p_pre;
                    end
                    if (cyc == gate_e + S + 1) begin
                        m_en = 1; m_done = 1; m_ready = 1;
                        active = 1'b0;
                    end
                end
            end else if (cfg_valid) begin
                r = ref_ratio(int'(cfg_prescale));
                if (r == 0) m_err = 1;
                else if (r == m_ratio) m_done = 1;
                else begin
                    active = 1'b1; waiting = 1'b1; m_ready = 0;
                    p_ratio = r; p_pre = int'(cfg_prescale);
                end
            end
        end
    end

    bit chk_en = 1'b0;
    bit rst_seen = 1'b0;
    int prev_ratio = 1, prev_en = 1;

    always @(negedge rst_n) rst_seen = 1'b1;

    // Compare process: every output against the model, plus invariants.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cfg_ready", int'(cfg_ready), m_ready);
            chk("cfg_done", int'(cfg_done), m_done);
            chk("cfg_err", int'(cfg_err), m_err);
            chk("div_en", int'(div_en), m_en);
            chk("div_ratio", int'(div_ratio), m_ratio);
            chk("cur_prescale", int'(cur_prescale), m_pre);
            chk("done_err_exclusive", int'(cfg_done & cfg_err), 0);
            if (!rst_seen && int'(div_ratio) != prev_ratio)
                chk("ratio_change_gated", int'(div_en) + prev_en, 0);
        end
        prev_ratio = int'(div_ratio);
        prev_en    = int'(div_en);
        rst_seen   = 1'b0;
    end

    // Issues a request; caller is positioned at a falling edge.
    task automatic req(input logic [5:0] p);
        cfg_valid    = 1'b1;
        cfg_prescale = p;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Full change sequence; lat counts edges after the accept edge.
    task automatic run_seq(input logic [5:0] p, input int k, input int poke,
                           output int lat, output int enlow, output int rchg);
        int r0;
        r0 = int'(div_ratio);
        rx_busy = (k > 0);
        req(p);
        lat = 0; enlow = 0; rchg = 0;
        while (!cfg_done && lat < LIMIT) begin
            if (!div_en) enlow++;
            if (int'(div_ratio) != r0 && rchg == 0) rchg = lat;
            if (lat <= k) chk("en_held_while_busy", int'(div_en), 1);
            if (lat == k) rx_busy = 1'b0;
            if (poke != 0 && lat == poke) begin
                cfg_valid = 1'b1; cfg_prescale = 6'd16;
            end else begin
                cfg_valid = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        cfg_valid = 1'b0;
        chk("seq_done_seen", int'(cfg_done), 1);
    endtask

    initial begin
        int lat, enlow, rchg;
        #3 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("rst_ready", int'(cfg_ready), 1);
        chk("rst_en", int'(div_en), 1);
        chk("rst_ratio", int'(div_ratio), 1);
        chk("rst_prescale", int'(cur_prescale), 32);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Prescale 8 with receiver idle.
        run_seq(6'd8, 0, 0, lat, enlow, rchg);
        chk("p8_latency", lat, 6);
        chk("p8_en_low_cycles", enlow, 5);
        chk("p8_ratio_change_at", rchg, 5);
        chk("p8_ratio", int'(div_ratio), 4);
        chk("p8_prescale", int'(cur_prescale), 8);

        // Receiver busy before and for 10 cycles after the accept.
        rx_busy = 1'b1;
        repeat (3) @(negedge clk);
        run_seq(6'd4, 10, 0, lat, enlow, rchg);
        chk("p4_busy_latency", lat, 16);
        chk("p4_ratio", int'(div_ratio), 8);
        chk("p4_prescale", int'(cur_prescale), 4);
        @(negedge clk);

        // Illegal prescales, singly then back-to-back.
        req(6'd20);
        chk("ill20_err", int'(cfg_err), 1);
        chk("ill20_ready", int'(cfg_ready), 1);
        chk("ill20_ratio", int'(div_ratio), 8);
        @(negedge clk);
        chk("ill20_err_single", int'(cfg_err), 0);
        req(6'd0);
        chk("ill0_err", int'(cfg_err), 1);
        @(negedge clk);
        req(6'd63);
        chk("ill63_err", int'(cfg_err), 1);
        chk("ill63_en", int'(div_en), 1);
        cfg_valid = 1'b1;
        cfg_prescale = 6'd20;
        @(negedge clk);
        chk("b2b_err_a", int'(cfg_err), 1);
        cfg_prescale = 6'd0;
        @(negedge clk);
        chk("b2b_err_b", int'(cfg_err), 1);
        cfg_prescale = 6'd63;
        @(negedge clk);
        chk("b2b_err_c", int'(cfg_err), 1);
        chk("b2b_ready", int'(cfg_ready), 1);
        cfg_valid = 1'b0;

        // Back to ratio 1, then same-ratio requests accepted in the DONE cycle.
        run_seq(6'd32, 0, 0, lat, enlow, rchg);
        chk("p32_ratio", int'(div_ratio), 1);
        req(6'd32);
        chk("same_done", int'(cfg_done), 1);
        chk("same_en", int'(div_en), 1);
        cfg_valid = 1'b1;
        cfg_prescale = 6'd32;
        @(negedge clk);
        chk("same_b2b_done", int'(cfg_done), 1);
        cfg_valid = 1'b0;
        @(negedge clk);

        // Request ignored while a sequence is in flight.
        run_seq(6'd8, 0, 3, lat, enlow, rchg);
        chk("poke_latency", lat, 6);
        chk("poke_ratio", int'(div_ratio), 4);
        chk("poke_prescale", int'(cur_prescale), 8);
        @(negedge clk);

        // Reset while gating.
        req(6'd4);
        repeat (2) @(negedge clk);
        chk("mid_gate_en_low", int'(div_en), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_en", int'(div_en), 1);
        chk("rst_mid_ratio", int'(div_ratio), 1);
        chk("rst_mid_prescale", int'(cur_prescale), 32);
        chk("rst_mid_ready", int'(cfg_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("no_done_after_rst", int'(cfg_done), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clkdiv_cfg_ctrl.md
# clkdiv_cfg_ctrl

Configuration sequencer for the RX clock divider. Accepts prescale change requests from the register-file side, decodes the prescale into a divide ratio, and waits until the UART receiver is idle. It then gates the divider, loads the new ratio and re-enables the divider, so the divided clock never glitches mid-frame. It sits between the register file and the integer clock divider in the reference (TX/REF) clock domain.

## Interface
- SETTLE_CYCLES, 4: cycles DIV_EN is held low before the new ratio is loaded (≥1)
- CNT_WIDTH, 3: width of the settle counter; must hold SETTLE_CYCLES
- CLK  in  1  block clock
- RST  in  1  asynchronous, active-low reset
- CFG_VALID  in  1  change request; accepted on a rising CLK edge when CFG_READY=1
- CFG_PRESCALE  in  6  requested prescale; legal values 32, 16, 8, 4
- CFG_READY  out  1  controller can accept a request
- CFG_DONE  out  1  one-cycle pulse: request completed, ratio applied (or unchanged)
- CFG_ERR  out  1  one-cycle pulse: request rejected (illegal prescale)
- RX_BUSY  in  1  receiver mid-frame; gating is deferred while high
- DIV_EN  out  1  clock-divider enable
- DIV_RATIO  out  4  divide ratio driven to the divider
- CUR_PRESCALE  out  6  prescale currently in effect

## Operation
- Decode: 32→1, 16→2, 8→4, 4→8. Any other value is illegal. There is no fallback to the default ratio; illegal requests are rejected.
- States: IDLE, WAIT_IDLE, GATE, LOAD.
- IDLE:
  - CFG_READY=1.
  - On accept with an illegal prescale: the next cycle raises CFG_ERR=1. State stays IDLE; DIV_RATIO, CUR_PRESCALE and DIV_EN are unchanged.
  - On accept with a decoded ratio equal to DIV_RATIO: the next cycle raises CFG_DONE=1 without gating. State stays IDLE.
  - On accept otherwise: capture the prescale and ratio into pending registers and go to WAIT_IDLE.
- WAIT_IDLE:
  - CFG_READY=0. Stay while RX_BUSY=1; there is no timeout.
  - When RX_BUSY is sampled 0, go to GATE. DIV_EN becomes 0 and the counter clears to 0.
- GATE:
  - DIV_EN=0. The counter increments each cycle.
  - When the counter reaches SETTLE_CYCLES-1, go to LOAD. DIV_RATIO and CUR_PRESCALE take the pending values.
  - RX_BUSY is ignored in this state.
- LOAD:
  - DIV_EN=0 with the new ratio stable for one cycle.
  - Then go to IDLE with DIV_EN=1, CFG_DONE=1 and CFG_READY=1 in the same cycle.
- All outputs are registered. CFG_DONE and CFG_ERR are never high together and are never high for two consecutive cycles from one request.
- CFG_VALID while CFG_READY=0 is ignored; it is not queued.
- Back-to-back requests are allowed:
  - A request may be accepted in the same cycle CFG_DONE or CFG_ERR is high.
  - A request may be accepted in the cycle immediately after a same-ratio or illegal accept.

## Timing
- Reset (RST=0, async): state IDLE, CFG_READY=1, CFG_DONE=0, CFG_ERR=0, DIV_EN=1, DIV_RATIO=1, CUR_PRESCALE=32, counter 0, pending registers cleared.
- Reset mid-sequence (any state) returns all outputs to their reset values immediately. No CFG_DONE is issued.
- Accept at edge t with RX_BUSY=0 throughout:
  - After edge t: WAIT_IDLE, CFG_READY=0.
  - After edge t+1: DIV_EN=0.
  - After edge t+1+SETTLE_CYCLES: DIV_RATIO updated.
  - After edge t+2+SETTLE_CYCLES: DIV_EN=1, CFG_DONE=1, CFG_READY=1.
  - Total latency accept→DONE is SETTLE_CYCLES+2 cycles (6 at default).
- RX_BUSY high for k cycles after accept delays every subsequent event by k cycles.
- Same-ratio or illegal request: CFG_DONE or CFG_ERR is high in the cycle after the accept edge. CFG_READY never drops.
- DIV_RATIO changes only while DIV_EN=0, and only at least SETTLE_CYCLES cycles after DIV_EN fell.

## Test plan
- Reset, then request prescale 8 with RX_BUSY=0:
  - DIV_EN low for 5 cycles.
  - DIV_RATIO 1→4 one cycle before DIV_EN rises.
  - CFG_DONE exactly 6 cycles after accept; CUR_PRESCALE=8.
- RX_BUSY held high for 10 cycles, then request prescale 4: DIV_EN stays 1 until RX_BUSY falls, then the normal sequence runs. CFG_DONE arrives at 16 cycles and DIV_RATIO=8.
- Illegal prescale 20, and also 0 and 63: one-cycle CFG_ERR each, DIV_RATIO/DIV_EN unchanged, CFG_READY stays 1. Repeat back-to-back on consecutive cycles.
- Request prescale 32 while ratio is 1: CFG_DONE the next cycle and DIV_EN never drops. Then pulse CFG_VALID with prescale 16 during an active sequence: the request is ignored, and the final ratio is the one first accepted.
- Assert RST mid-GATE: DIV_EN=1, DIV_RATIO=1, CUR_PRESCALE=32, CFG_READY=1 immediately. No CFG_DONE follows.
- Checker throughout: DIV_RATIO never changes while DIV_EN=1, and CFG_DONE and CFG_ERR are never high together.
